mygo_chan_byte_packer: RTL and testbench
========================================

Name: mygo_chan_byte_packer

Overview:
- Channel-reader process that consumes an 8-bit channel carrying little-endian byte streams, as produced by a word-to-byte splitting stage.
- Reassembles each group of 4 bytes into one 32-bit word and writes it to a 32-bit output channel.
- After NUM_WORDS words it writes a single 1 to a 1-bit done channel, then halts.
- Sits between the i8 FIFO's read side and the i32/i1 FIFOs' write sides, using the same data/valid/ready channel protocol as the generated FIFOs.

Parameters:
NUM_WORDS, 4, number of 32-bit words to assemble before signalling done (0 allowed)
LSB_FIRST, 1, 1 = first byte received lands in bits [7:0]; 0 = first byte lands in bits [31:24]

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low (asserted when rst==0)
chan_in_rdata  input  8  byte from i8 FIFO read side
chan_in_rvalid  input  1  FIFO holds a byte
chan_in_rready  output  1  packer accepts a byte this cycle
chan_out_wdata  output  32  assembled word to i32 FIFO
chan_out_wvalid  output  1  word presented
chan_out_wready  input  1  i32 FIFO can accept
chan_done_wdata  output  1  done token value (always 1 when valid)
chan_done_wvalid  output  1  done token presented
chan_done_wready  input  1  i1 FIFO can accept
word_count  output  $clog2(NUM_WORDS+1) (min 1)  words delivered so far

Behaviour:
- Transfer rule on every channel: a transfer occurs on a cycle where valid && ready are both 1 at the rising edge. Valid, once raised, is held with stable data until the transfer occurs.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path except none (rready depends on state only).
- Reset (rst==0 at posedge):
  - state=S_INIT, byte_idx=0, shift register=0, word_count=0.
  - chan_in_rready=0, chan_out_wvalid=0, chan_out_wdata=0, chan_done_wvalid=0, chan_done_wdata=0.
  - A reset mid-operation discards any partial word and any pending output; no transfer completes on the reset cycle.
- FSM (3-bit state):
  - S_INIT: one cycle after reset release. Goes to S_RECV if NUM_WORDS>0, else to S_DONE.
  - S_RECV: chan_in_rready=1. On each byte transfer, write the byte into lane byte_idx (lane reversed if LSB_FIRST=0) and increment byte_idx. On the transfer with byte_idx==3: byte_idx wraps to 0, the full word is loaded into chan_out_wdata, and the FSM goes to S_SEND. With no transfer, the FSM stays.
  - S_SEND: chan_in_rready=0 (no overlap of receive and send), chan_out_wvalid=1. On transfer: word_count+1. If the new count == NUM_WORDS, go to S_DONE; else go to S_RECV. Backpressure holds the state indefinitely.
  - S_DONE: chan_done_wvalid=1, chan_done_wdata=1. On transfer go to S_HALT.
  - S_HALT: all valids/readies 0; self-loop until reset. Bytes arriving here are not consumed.
  - Unused encodings go to S_HALT.
- Latency:
  - First byte can be accepted in the 2nd cycle after reset release.
  - A word is presented on chan_out in the cycle after its 4th byte transfers.
  - Best-case throughput is 1 word per 5 cycles.
- Width rules:
  - word_count saturates at NUM_WORDS; it never wraps.
  - byte_idx is 2 bits and wraps modulo 4.

Decomposition:
- Shared package mygo_chan_pkg:
  - state enum (S_INIT, S_RECV, S_SEND, S_DONE, S_HALT)
  - BYTES_PER_WORD=4 constant
  - function lane_of(idx, lsb_first)
- Sub-module mygo_byte_shreg: a 4-lane byte assembly register with load/lane-select/clear. The FSM and handshake logic stay in the top.

Test Plan:
- Basic little-endian: bytes 0x04,0x00,0x00,0x00 then 0x08,0,0,0 with valid always 1 and wready=1 -> chan_out words 0x00000004, then 0x00000008; word_count goes 1, then 2.
- Full run with NUM_WORDS=4: 16 bytes 0x11..0x44 patterned -> exactly 4 words (e.g. first word 0x44332211 for bytes 11,22,33,44), then one done transfer with wdata=1, then rready stays 0 forever.
- Backpressure: hold chan_out_wready=0 for 10 cycles after the 4th byte -> wvalid stays 1 with constant data, rready=0; with 8 bytes offered only 4 are consumed; the word transfers on the first wready=1 cycle.
- Bubbly input: rvalid toggling pseudo-randomly -> identical word sequence to the no-bubble case; byte order is preserved.
- Reset mid-word: reset after 2 bytes accepted, then send 0xAA,0xBB,0xCC,0xDD -> first word is 0xDDCCBBAA; no stale bytes appear.
- Edge parameters: NUM_WORDS=0 -> the done token is presented in the 2nd cycle after reset, and no byte is ever accepted. LSB_FIRST=0 with bytes 0x12,0x34,0x56,0x78 -> word 0x12345678.

Source files
------------

// File: rtl/mygo_chan_pkg.sv
// Shared types for the channel byte packer: FSM states, word geometry and
// byte-lane mapping.
package mygo_chan_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_RECV = 3'd1,
        S_SEND = 3'd2,
        S_DONE = 3'd3,
        S_HALT = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // Arrival order idx maps to lane idx (little-endian) or 3-idx (big-endian).
    function automatic logic [1:0] lane_of(input logic [1:0] idx, input logic lsb_first);
        return lsb_first ? idx : (2'd3 - idx);
    endfunction

endpackage

// File: rtl/mygo_byte_shreg.sv
// Four-lane byte assembly register; merged_o shows the word as it would look
// with the incoming byte already written, so the top can capture it same-cycle.
module mygo_byte_shreg
    import mygo_chan_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          wr_i,
    input  logic [1:0]                    lane_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   merged_o
);

    logic [BYTES_PER_WORD-1:0][7:0] lanes_q, lanes_d, merged;

    always_comb begin
        merged         = lanes_q;
        merged[lane_i] = byte_i;
    end

    always_comb begin
        lanes_d = lanes_q;
        if (clr_i)
            lanes_d = '0;
        else if (wr_i)
            lanes_d = merged;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            lanes_q <= '0;
        else
            lanes_q <= lanes_d;
    end

    assign merged_o = merged;

endmodule

// File: rtl/mygo_chan_byte_packer.sv
// Reads bytes from an 8-bit channel, packs groups of four into 32-bit words,
// emits NUM_WORDS words and then a single done token before halting.
module mygo_chan_byte_packer
    import mygo_chan_pkg::*;
#(
    parameter int   NUM_WORDS = 4,
    parameter bit   LSB_FIRST = 1'b1,
    localparam int  CW        = (NUM_WORDS > 0) ? $clog2(NUM_WORDS + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    chan_in_rdata,
    input  logic          chan_in_rvalid,
    output logic          chan_in_rready,
    output logic [31:0]   chan_out_wdata,
    output logic          chan_out_wvalid,
    input  logic          chan_out_wready,
    output logic          chan_done_wdata,
    output logic          chan_done_wvalid,
    input  logic          chan_done_wready,
    output logic [CW-1:0] word_count
);

    localparam logic [CW-1:0] NW = CW'(NUM_WORDS);

    state_e          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CW-1:0]   count_q, count_d, count_inc;
    logic [31:0]     merged;
    logic            in_xfer, last_byte, out_xfer, done_xfer;

    assign in_xfer   = chan_in_rvalid && chan_in_rready;
    assign last_byte = in_xfer && (byte_idx_q == 2'd3);
    assign out_xfer  = chan_out_wvalid && chan_out_wready;
    assign done_xfer = chan_done_wvalid && chan_done_wready;
    assign count_inc = count_q + 1'b1;

    mygo_byte_shreg u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (last_byte),
        .wr_i     (in_xfer),
        .lane_i   (lane_of(byte_idx_q, LSB_FIRST)),
        .byte_i   (chan_in_rdata),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_INIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = (NUM_WORDS > 0) ? S_RECV : S_DONE;
            S_RECV: if (last_byte) state_d = S_SEND;
            S_SEND: if (out_xfer)  state_d = (count_inc == NW) ? S_DONE : S_RECV;
            S_DONE: if (done_xfer) state_d = S_HALT;
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Handshake outputs decode the state only; receive and send never overlap.
    always_comb begin
        chan_in_rready   = 1'b0;
        chan_out_wvalid  = 1'b0;
        chan_done_wvalid = 1'b0;
        chan_done_wdata  = 1'b0;
        case (state_q)
            S_RECV: chan_in_rready = 1'b1;
            S_SEND: chan_out_wvalid = 1'b1;
            S_DONE: begin
                chan_done_wvalid = 1'b1;
                chan_done_wdata  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_idx_d = in_xfer ? byte_idx_q + 2'd1 : byte_idx_q;
        wdata_d    = last_byte ? merged : wdata_q;
        count_d    = (out_xfer && count_q != NW) ? count_inc : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx_q <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
        end
    end

    assign chan_out_wdata = wdata_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_mygo_chan_byte_packer.sv
// Randomized self-checking bench: three packer instances (default, NUM_WORDS=0,
// big-endian) driven by byte queues and compared with a packing reference.
module tb_mygo_chan_byte_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // a_: NUM_WORDS=4 LSB_FIRST=1, z_: NUM_WORDS=0, r_: NUM_WORDS=2 LSB_FIRST=0
    logic [7:0]  a_rdata = '0, z_rdata = '0, r_rdata = '0;
    logic        a_rvalid = 0, z_rvalid = 0, r_rvalid = 0;
    logic        a_rready, z_rready, r_rready;
    logic [31:0] a_wdata, z_wdata, r_wdata;
    logic        a_wvalid, z_wvalid, r_wvalid;
    logic        a_wready = 0, z_wready = 0, r_wready = 0;
    logic        a_dwdata, z_dwdata, r_dwdata;
    logic        a_dvalid, z_dvalid, r_dvalid;
    logic        a_dready = 0, z_dready = 0, r_dready = 0;
    logic [2:0]  a_cnt;
    logic [0:0]  z_cnt;
    logic [1:0]  r_cnt;

    mygo_chan_byte_packer #(.NUM_WORDS(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .chan_in_rdata(a_rdata), .chan_in_rvalid(a_rvalid), .chan_in_rready(a_rready),
        .chan_out_wdata(a_wdata), .chan_out_wvalid(a_wvalid), .chan_out_wready(a_wready),
        .chan_done_wdata(a_dwdata), .chan_done_wvalid(a_dvalid), .chan_done_wready(a_dready),
        .word_count(a_cnt));

    mygo_chan_byte_packer #(.NUM_WORDS(0), .LSB_FIRST(1'b1)) dut_zero (
        .clk(clk), .rst(rst),
        .chan_in_rdata(z_rdata), .chan_in_rvalid(z_rvalid), .chan_in_rready(z_rready),
        .chan_out_wdata(z_wdata), .chan_out_wvalid(z_wvalid), .chan_out_wready(z_wready),
        .chan_done_wdata(z_dwdata), .chan_done_wvalid(z_dvalid), .chan_done_wready(z_dready),
        .word_count(z_cnt));

    mygo_chan_byte_packer #(.NUM_WORDS(2), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst),
        .chan_in_rdata(r_rdata), .chan_in_rvalid(r_rvalid), .chan_in_rready(r_rready),
        .chan_out_wdata(r_wdata), .chan_out_wvalid(r_wvalid), .chan_out_wready(r_wready),
        .chan_done_wdata(r_dwdata), .chan_done_wvalid(r_dvalid), .chan_done_wready(r_dready),
        .word_count(r_cnt));

    int checks = 0;
    int errors = 0;

    logic [7:0]  a_src[$], r_src[$], a_cons[$];
    logic [31:0] a_got[$], r_got[$];
    int a_ptr, r_ptr, a_done, r_done, z_done, z_acc;
    int wr_mode;   // 0: wready=1, 1: wready=0, 2: random
    bit bubbles;

    function automatic logic [31:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input bit lsb);
        return lsb ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
    endfunction

    // One clock: log transfers seen at the negedge, then drive fresh inputs at posedge+1.
    task automatic step();
        bit a_in = 0;
        bit r_in = 0;
        @(negedge clk);
        if (rst) begin
            if (a_rvalid && a_rready) begin a_cons.push_back(a_rdata); a_ptr++; a_in = 1; end
            if (a_wvalid && a_wready) a_got.push_back(a_wdata);
            if (a_dvalid && a_dready && a_dwdata) a_done++;
            if (r_rvalid && r_rready) begin r_ptr++; r_in = 1; end
            if (r_wvalid && r_wready) r_got.push_back(r_wdata);
            if (r_dvalid && r_dready && r_dwdata) r_done++;
            if (z_rvalid && z_rready) z_acc++;
            if (z_dvalid && z_dready && z_dwdata) z_done++;
        end
        @(posedge clk);
        #1;
        if (!a_rvalid || a_in)
            a_rvalid = (a_ptr < a_src.size()) && (!bubbles || $urandom_range(1) == 1);
        a_rdata  = (a_ptr < a_src.size()) ? a_src[a_ptr] : 8'h00;
        a_wready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? 1'b0 : ($urandom_range(1) == 1);
        a_dready = 1'b1;
        r_rvalid = r_ptr < r_src.size();
        r_rdata  = (r_ptr < r_src.size()) ? r_src[r_ptr] : 8'h00;
        r_wready = 1'b1;
        r_dready = 1'b1;
        z_rvalid = 1'b1;
        z_rdata  = 8'($urandom);
        z_dready = 1'b1;
        if (r_in) r_in = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        a_src.delete(); r_src.delete(); a_cons.delete(); a_got.delete(); r_got.delete();
        a_ptr = 0; r_ptr = 0; a_done = 0; r_done = 0; z_done = 0;
        wr_mode = 0; bubbles = 0;
        a_rvalid = 0; r_rvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_rvalid = 1; a_wready = 1; a_dready = 1; a_rdata = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_rready, a_wvalid, a_dvalid, a_dwdata} !== 4'b0 || a_wdata !== 32'h0 || a_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs got rr=%b wv=%b dv=%b dd=%b wd=%h cnt=%0d exp all 0",
                     a_rready, a_wvalid, a_dvalid, a_dwdata, a_wdata, a_cnt);
        end
        checks++;
        if (z_dvalid !== 1'b0 || r_rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_other_insts got z_dv=%b r_rr=%b exp 0 0", z_dvalid, r_rready);
        end
        do_reset();
        checks++;
        if (a_rready !== 1'b0) begin
            errors++; $display("FAIL init_rready got %b exp 0", a_rready);
        end
        a_src.push_back(8'h01);
        step();
        checks++;
        if (a_rready !== 1'b1 || a_cons.size() != 0) begin
            errors++; $display("FAIL first_accept_cycle got rr=%b n=%0d exp 1 0", a_rready, a_cons.size());
        end
        step();
        checks++;
        if (a_cons.size() != 1) begin
            errors++; $display("FAIL first_byte_taken got %0d exp 1", a_cons.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes[8] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};
        bit seen1 = 0;
        do_reset();
        foreach (bytes[i]) a_src.push_back(bytes[i]);
        for (int i = 0; i < 40 && a_got.size() < 2; i++) begin
            step();
            if (a_got.size() == 1 && !seen1) begin
                seen1 = 1;
                checks++;
                if (a_cnt !== 3'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", a_cnt); end
            end
        end
        checks++;
        if (a_got.size() != 2) begin
            errors++; $display("FAIL basic_nwords got %0d exp 2", a_got.size());
        end else begin
            checks++;
            if (a_got[0] !== 32'h00000004 || a_got[1] !== 32'h00000008) begin
                errors++; $display("FAIL basic_words got %h %h exp 00000004 00000008", a_got[0], a_got[1]);
            end
        end
        checks++;
        if (a_cnt !== 3'd2) begin errors++; $display("FAIL basic_count2 got %0d exp 2", a_cnt); end
    endtask

    task automatic test_full_run();
        bit bad = 0;
        do_reset();
        for (int i = 0; i < 20; i++) a_src.push_back(8'(8'h11 * (i % 4 + 1) + i / 4));
        repeat (21) step();
        checks++;
        if (a_got.size() != 4 || a_done != 0) begin
            errors++; $display("FAIL full_timing got words=%0d done=%0d exp 4 0", a_got.size(), a_done);
        end
        for (int k = 0; k < 4 && k < a_got.size(); k++)
            if (a_got[k] !== pack4(a_src[4*k], a_src[4*k+1], a_src[4*k+2], a_src[4*k+3], 1'b1)) bad = 1;
        checks++;
        if (bad || a_got.size() == 0 || a_got[0] !== 32'h44332211) begin
            errors++; $display("FAIL full_words got first=%h exp 44332211 (or later word wrong)",
                               (a_got.size() > 0) ? a_got[0] : 32'hx);
        end
        step();
        checks++;
        if (a_done != 1) begin errors++; $display("FAIL full_done_at_22 got %0d exp 1", a_done); end
        repeat (10) step();
        checks++;
        if (a_rready !== 1'b0 || a_dvalid !== 1'b0 || a_cons.size() != 16 || a_done != 1 || a_cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_halt got rr=%b dv=%b cons=%0d done=%0d cnt=%0d exp 0 0 16 1 4",
                     a_rready, a_dvalid, a_cons.size(), a_done, a_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held, exp;
        bit bad = 0;
        do_reset();
        for (int i = 0; i < 8; i++) a_src.push_back(8'($urandom));
        exp = pack4(a_src[0], a_src[1], a_src[2], a_src[3], 1'b1);
        wr_mode = 1;
        for (int i = 0; i < 20 && a_wvalid !== 1'b1; i++) step();
        held = a_wdata;
        repeat (10) begin
            step();
            if (a_wvalid !== 1'b1 || a_wdata !== held || a_rready !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL bp_hold got wv=%b wd=%h rr=%b exp 1 %h 0", a_wvalid, a_wdata, a_rready, held); end
        checks++;
        if (held !== exp || a_cons.size() != 4 || a_got.size() != 0) begin
            errors++; $display("FAIL bp_state got wd=%h cons=%0d words=%0d exp %h 4 0", held, a_cons.size(), a_got.size(), exp);
        end
        wr_mode = 0;
        a_wready = 1'b1;
        step();
        checks++;
        if (a_got.size() != 1 || a_got[0] !== exp) begin
            errors++; $display("FAIL bp_release got n=%0d exp 1 word %h", a_got.size(), exp);
        end
    endtask

    task automatic test_bubbly();
        bit bad = 0;
        do_reset();
        for (int i = 0; i < 16; i++) a_src.push_back(8'($urandom));
        bubbles = 1;
        wr_mode = 2;
        for (int i = 0; i < 600 && a_done == 0; i++) step();
        for (int k = 0; k < 4 && k < a_got.size(); k++)
            if (a_got[k] !== pack4(a_src[4*k], a_src[4*k+1], a_src[4*k+2], a_src[4*k+3], 1'b1)) bad = 1;
        for (int k = 0; k < a_cons.size(); k++)
            if (a_cons[k] !== a_src[k]) bad = 1;
        checks++;
        if (bad || a_got.size() != 4 || a_cons.size() != 16) begin
            errors++; $display("FAIL bubbly_words got words=%0d cons=%0d order_bad=%0d exp 4 16 0", a_got.size(), a_cons.size(), bad);
        end
        checks++;
        if (a_done != 1 || a_cnt !== 3'd4) begin
            errors++; $display("FAIL bubbly_done got done=%0d cnt=%0d exp 1 4", a_done, a_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        a_src.push_back(8'($urandom));
        a_src.push_back(8'($urandom));
        for (int i = 0; i < 20 && a_cons.size() < 2; i++) step();
        do_reset();
        a_src.push_back(8'hAA); a_src.push_back(8'hBB);
        a_src.push_back(8'hCC); a_src.push_back(8'hDD);
        for (int i = 0; i < 30 && a_got.size() < 1; i++) step();
        checks++;
        if (a_got.size() != 1 || a_got[0] !== 32'hDDCCBBAA) begin
            errors++; $display("FAIL mid_reset_word got n=%0d w=%h exp 1 ddccbbaa", a_got.size(),
                               (a_got.size() > 0) ? a_got[0] : 32'hx);
        end
    endtask

    task automatic test_edge_params();
        logic [31:0] exp1;
        do_reset();
        r_src.push_back(8'h12); r_src.push_back(8'h34);
        r_src.push_back(8'h56); r_src.push_back(8'h78);
        for (int i = 0; i < 4; i++) r_src.push_back(8'($urandom));
        exp1 = pack4(r_src[4], r_src[5], r_src[6], r_src[7], 1'b0);
        checks++;
        if (z_dvalid !== 1'b0) begin errors++; $display("FAIL zero_init got dv=%b exp 0", z_dvalid); end
        step();
        checks++;
        if (z_dvalid !== 1'b1 || z_dwdata !== 1'b1) begin
            errors++; $display("FAIL zero_done_present got dv=%b dd=%b exp 1 1", z_dvalid, z_dwdata);
        end
        repeat (30) step();
        checks++;
        if (z_done != 1 || z_acc != 0 || z_dvalid !== 1'b0 || z_cnt !== 1'b0) begin
            errors++; $display("FAIL zero_halt got done=%0d acc=%0d dv=%b cnt=%0d exp 1 0 0 0", z_done, z_acc, z_dvalid, z_cnt);
        end
        checks++;
        if (r_got.size() != 2 || r_got[0] !== 32'h12345678 || r_got[1] !== exp1) begin
            errors++; $display("FAIL msb_words got n=%0d w0=%h exp 2 12345678 then %h", r_got.size(),
                               (r_got.size() > 0) ? r_got[0] : 32'hx, exp1);
        end
        checks++;
        if (r_done != 1 || r_cnt !== 2'd2) begin
            errors++; $display("FAIL msb_done got done=%0d cnt=%0d exp 1 2", r_done, r_cnt);
        end
    endtask

    initial begin
        z_acc = 0;
        test_reset();
        test_basic();
        test_full_run();
        test_backpressure();
        test_bubbly();
        test_reset_mid_word();
        test_edge_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
